// File: rtl/mux_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_pkg
// Shared definitions for the mux41 scan sequencer: FSM state encoding and the
// channel geometry of the 4:1 mux being scanned.
// -----------------------------------------------------------------------------
package mux_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      OUT  = 2'd2
   } state_e;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

endpackage : mux_scan_ctrl_pkg

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Counts cycles spent on the current mux channel and flags the sample point
// and the last cycle of the dwell window.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - force the count to zero at the next edge (priority over enable)
//   enable      - increment the count at the next edge
//   at_settle   - count equals SETTLE (sample y this cycle)
//   at_last     - count equals DWELL-1 (last cycle on this channel)
// -----------------------------------------------------------------------------
module dwell_counter
   import mux_scan_ctrl_pkg::*;
#(
   parameter int DWELL  = 4,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic at_settle,
   output logic at_last
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear wins over increment.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = {CNT_W{1'b0}};
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign at_settle = (count_q == CNT_W'(SETTLE));
   assign at_last   = (count_q == CNT_W'(DWELL - 1));

endmodule : dwell_counter

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Steps the mux41 select through channels 0..3, holds each for DWELL cycles,
// samples y at offset SETTLE within each dwell and presents the assembled
// 4-bit word over a valid/ready handshake.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - one-cycle scan request, honoured only in IDLE
//   cont        - continuous mode, looked at only on the output handshake
//   y           - mux41 output
//   sel         - mux41 select (registered)
//   busy        - high whenever not IDLE (registered)
//   data        - assembled word, bit i = y sampled with sel=i (registered)
//   data_valid  - word available (registered)
//   data_ready  - consumer accepts the word
// -----------------------------------------------------------------------------
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter int DWELL  = 4,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cont,
   input  logic              y,
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic [NUM_CH-1:0] data,
   output logic              data_valid,
   input  logic              data_ready
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [NUM_CH-1:0] capture_q, capture_d;
   logic [NUM_CH-1:0] data_q, data_d;
   logic              data_valid_q, data_valid_d;
   logic              busy_q, busy_d;
   logic              at_settle_s, at_last_s;
   logic              xfer_s;
   logic              cnt_clear_s, cnt_enable_s;

   assign xfer_s = data_valid_q && data_ready;

   // Outside SCAN the counter sits at zero, so every scan starts from a clean count.
   assign cnt_enable_s = (state_q == SCAN);
   assign cnt_clear_s  = (state_q != SCAN) || at_last_s;

   dwell_counter #(
      .DWELL  (DWELL),
      .SETTLE (SETTLE),
      .CNT_W  (CNT_W)
   ) u_dwell_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (cnt_clear_s),
      .enable    (cnt_enable_s),
      .at_settle (at_settle_s),
      .at_last   (at_last_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = SCAN;
            else       state_d = IDLE;
         end
         SCAN: begin
            if (at_last_s && (sel_q == LAST_CH)) state_d = OUT;
            else                                 state_d = SCAN;
         end
         OUT: begin
            if (xfer_s) state_d = cont ? SCAN : IDLE;
            else        state_d = OUT;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values; everything leaves the block through flops.
   always_comb begin
      sel_d        = sel_q;
      capture_d    = capture_q;
      data_d       = data_q;
      data_valid_d = data_valid_q;
      case (state_q)
         IDLE: begin
            sel_d        = {SEL_W{1'b0}};
            data_valid_d = 1'b0;
         end
         SCAN: begin
            if (at_settle_s) capture_d[sel_q] = y;
            else             capture_d        = capture_q;
            if (at_last_s) begin
               if (sel_q == LAST_CH) begin
                  // capture_d already holds the last bit when SETTLE == DWELL-1
                  data_d       = capture_d;
                  data_valid_d = 1'b1;
               end else begin
                  sel_d = sel_q + 2'd1;
               end
            end else begin
               sel_d = sel_q;
            end
         end
         OUT: begin
            if (xfer_s) begin
               sel_d        = {SEL_W{1'b0}};
               data_valid_d = 1'b0;
            end else begin
               data_valid_d = 1'b1;
            end
         end
         default: begin
            sel_d        = {SEL_W{1'b0}};
            data_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Output and capture registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q        <= {SEL_W{1'b0}};
         capture_q    <= {NUM_CH{1'b0}};
         data_q       <= {NUM_CH{1'b0}};
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         sel_q        <= sel_d;
         capture_q    <= capture_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign sel        = sel_q;
   assign busy       = busy_q;
   assign data       = data_q;
   assign data_valid = data_valid_q;

endmodule : mux_scan_ctrl
